// File: rtl/fsm1_pkg.sv
// Shared fsm1 handshake types. The responder states carry an RS_ prefix so
// they can sit beside the initiator's state_e without name clashes.
package fsm1_pkg;

   typedef enum logic [2:0] {
      RS_IDLE  = 3'd0,
      RS_WAIT  = 3'd1,
      RS_FETCH = 3'd2,
      RS_DATA  = 3'd3,
      RS_XXX   = 3'd7
   } resp_state_e;

endpackage

// File: rtl/fsm1_wait_cnt.sv
// Wait-state down-counter for the fsm1 responder. done flags the last wait
// cycle, or a zero load so the caller can skip the wait phase entirely.
module fsm1_wait_cnt #(
   parameter int WAIT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WAIT_W-1:0] value,
   input  logic              enable,
   output logic              done
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)        cnt_d = value;
      else if (enable) cnt_d = cnt_q - WAIT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done = load ? (value == '0) : (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/fsm1_resp.sv
// Responder end of the fsm1 rd/ws/ds read handshake: programmable wait
// states, one memory fetch per transaction, auto-incrementing address.
module fsm1_resp
   import fsm1_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int WAIT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd,
   input  logic              ds,
   input  logic [WAIT_W-1:0] wait_cfg,
   output logic              ws,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] data,
   output logic              data_vld,
   output logic              busy,
   output logic              err
);

   resp_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ws_q, ws_d;
   logic              re_q, re_d;
   logic              vld_q, vld_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              cnt_load, cnt_en, cnt_done;

   fsm1_wait_cnt #(.WAIT_W(WAIT_W)) u_wait_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (cnt_load),
      .value  (wait_cfg),
      .enable (cnt_en),
      .done   (cnt_done)
   );

   // Stray ds only raises err; it never stalls the wait/fetch progression.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      err_d    = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      unique case (state_q)
         RS_IDLE: begin
            err_d = ds;
            if (rd) begin
               cnt_load = 1'b1;
               state_d  = cnt_done ? RS_FETCH : RS_WAIT;
            end
         end
         RS_WAIT: begin
            err_d = ds | ~rd;
            if (!rd) begin
               state_d = RS_IDLE;
            end else begin
               cnt_en = 1'b1;
               if (cnt_done) state_d = RS_FETCH;
            end
         end
         RS_FETCH: begin
            err_d = ds | ~rd;
            if (!rd) begin
               state_d = RS_IDLE;
            end else begin
               data_d  = mem_rdata;
               state_d = RS_DATA;
            end
         end
         RS_DATA: begin
            if (ds) begin
               state_d = RS_IDLE;
               addr_d  = addr_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = RS_XXX;
            addr_d  = 'x;
            data_d  = 'x;
            err_d   = 1'bx;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are registered and
   // line up with the state they describe.
   always_comb begin
      ws_d   = 1'b0;
      re_d   = 1'b0;
      vld_d  = 1'b0;
      busy_d = 1'b1;
      unique case (state_d)
         RS_IDLE:  busy_d = 1'b0;
         RS_WAIT:  ws_d   = 1'b1;
         RS_FETCH: re_d   = 1'b1;
         RS_DATA:  vld_d  = 1'b1;
         default: begin
            ws_d   = 1'bx;
            re_d   = 1'bx;
            vld_d  = 1'bx;
            busy_d = 1'bx;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RS_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         ws_q    <= 1'b0;
         re_q    <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ws_q    <= ws_d;
         re_q    <= re_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign ws       = ws_q;
   assign mem_re   = re_q;
   assign mem_addr = addr_q;
   assign data     = data_q;
   assign data_vld = vld_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule

// File: doc/fsm1_resp.md
Name: fsm1_resp

Overview:
Responder (slave) end of the fsm1 rd/ws/ds read handshake.
- Watches the initiator's rd strobe and inserts a programmable number of wait states on ws.
- Fetches one word from a combinational-read memory port and presents it on data/data_vld until the initiator signals completion on ds.
- Sits between an fsm1 initiator and a small register file or ROM; the address auto-increments per completed read.

Parameters:
- DATA_W, 8, width of read data.
- ADDR_W, 4, width of internal read address; wraps modulo 2**ADDR_W.
- WAIT_W, 4, width of wait-state configuration; 0..2**WAIT_W-1 wait cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rd  input  1  read strobe from initiator; high during its READ/DLY cycles.
- ds  input  1  done strobe from initiator; one-cycle pulse ending the transaction.
- wait_cfg  input  WAIT_W  number of wait-state cycles N; sampled only at transaction start.
- ws  output  1  wait-state indication to initiator (1 = not ready).
- mem_re  output  1  memory read enable, one cycle per transaction.
- mem_addr  output  ADDR_W  memory address; equals the internal address register.
- mem_rdata  input  DATA_W  memory read data, valid in the same cycle as mem_re (combinational read).
- data  output  DATA_W  captured read data.
- data_vld  output  1  data holds a valid word for the current transaction.
- busy  output  1  transaction in progress (state != IDLE).
- err  output  1  one-cycle protocol-error pulse.

Behaviour:
- Reset values: ws=0, mem_re=0, mem_addr=0, data=0, data_vld=0, busy=0, err=0; state=IDLE; wait counter=0.
- Reset is asynchronous. Asserting it mid-transaction aborts immediately, with no address increment.
- All outputs are registered and decoded from the next state. mem_addr is the address register.
- States: IDLE, WAIT, FETCH, DATA. The X default assigns X to state and outputs.
- IDLE:
  - rd=1 at cycle c0 latches wait_cfg into N.
  - If N=0, go to FETCH; otherwise load the counter with N and go to WAIT.
  - ds=1 in IDLE: err pulse, stay in IDLE.
- WAIT:
  - ws=1 and the counter decrements each cycle. ws is high in cycles c1..cN.
  - When the counter reaches 1, go to FETCH.
- FETCH (cycle cN+1):
  - ws=0 and mem_re=1.
  - data is loaded from mem_rdata at the end of the cycle.
  - Go to DATA.
- DATA (from cycle cN+2):
  - data_vld=1, ws=0 and rd is ignored.
  - ds=1: go to IDLE, increment the address (wrap 2**ADDR_W-1 -> 0), data_vld=0 from the next cycle. data keeps its last value.
- Abort: rd=0 while in WAIT or FETCH goes to IDLE with ws=0, an err pulse, no address increment and data_vld unchanged at 0.
- Stray ds: ds=1 in WAIT or FETCH gives an err pulse and no state change. ds and rd both high in IDLE starts the transaction and also pulses err.
- Alignment: the initiator samples ws only on alternate rd cycles (DLY), so ws must stay 0 from FETCH through DATA until ds. This guarantees the initiator sees ws=0 regardless of phase.
- Timing against an fsm1 initiator: data_vld is high no later than the first cycle ds is high.
- Back-to-back: rd=1 in the cycle after the return to IDLE starts a new transaction immediately. There is no idle bubble beyond the IDLE cycle itself.

Decomposition:
- Add resp_state_e {IDLE, WAIT, FETCH, DATA, XXX} to the shared fsm1_pkg. The enum value names are prefixed to avoid clashing with state_e.
- One sub-module, fsm1_wait_cnt, owns the wait counter:
  - inputs: load, value, enable
  - output: done (counter==1 or loaded zero)
  - width WAIT_W

Test Plan:
1. wait_cfg=0, mem_rdata=8'hA5 at addr 0, rd high from c0 -> ws never high; mem_re at c1; data=8'hA5 and data_vld=1 at c2; ds at c2 -> mem_addr=1 at c3.
2. wait_cfg=3 -> ws=1 in c1..c3; mem_re at c4; data_vld at c5; paired with the fsm1 initiator, ds occurs and the initiator returns to IDLE with rd low.
3. 16 back-to-back reads, wait_cfg=1, ADDR_W=4, addr 0 preloaded with 8'h00..15 pattern -> addresses 0..15 then wrap to 0; data sequence matches the memory contents; no err.
4. rd dropped at c2 with wait_cfg=5 -> err pulse at c3, ws=0, state IDLE, mem_addr unchanged, no mem_re.
5. ds pulsed in IDLE and again in WAIT -> one err pulse each, state and address unchanged, transaction then completes normally.
6. rst_n asserted mid-WAIT (wait_cfg=4, at c2) -> all outputs 0 asynchronously, addr=0; after release, a new read completes with correct timing.
